// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one word request, waits WAIT_CYCLES, performs the read or
// byte-masked write and returns the pre-access word over a response handshake.
module dmem_responder #(
  parameter int unsigned DEPTH       = 128,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  input  logic [3:0]       req_be,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_rdata,
  output logic             resp_err,
  output logic [CNT_W-1:0] txn_count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned WW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;
  typedef logic [31:0] mem_t [DEPTH];

  function automatic mem_t mem_init();
    mem_t m;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      m[i] = 32'(i);
    end
    return m;
  endfunction

  // Power-up contents are word[i] = i; reset leaves the array alone.
  logic [31:0] mem_q [DEPTH] = mem_init();

  state_e           state_q, state_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic             write_q, write_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       be_q, be_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] txn_q, txn_d;

  logic [AW-1:0] idx;
  logic [31:0]   old_word;
  logic [31:0]   merged;
  logic          acc_err;
  logic          mem_we;

  assign idx      = addr_q[AW+1:2];
  assign acc_err  = (addr_q[1:0] != 2'b00) || ({2'b00, addr_q[31:2]} >= DEPTH);
  assign old_word = acc_err ? 32'h0 : mem_q[idx];

  always_comb begin
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    txn_d   = txn_q;
    mem_we  = 1'b0;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          wait_d  = WW'(WAIT_CYCLES);
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (wait_q == '0) begin
          rdata_d = old_word;
          err_d   = acc_err;
          mem_we  = write_q && !acc_err;
          state_d = StResp;
        end else begin
          wait_d = wait_q - WW'(1);
        end
      end
      StResp: begin
        if (resp_ready) begin
          txn_d   = txn_q + CNT_W'(1);
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      wait_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      txn_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      txn_q   <= txn_d;
    end
  end

  always_ff @(posedge clk) begin
    write_q <= write_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    be_q    <= be_d;
  end

  // Reset in the commit cycle must suppress the write.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem_q[idx] <= merged;
  end

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = (state_q == StResp);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign txn_count  = txn_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: one instance with two wait states, one with none.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 128;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        resp_ready = 1'b0;

  logic        rr2, rv2, er2, rr0, rv0, er0;
  logic [31:0] rd2, rd0;
  logic [15:0] tc2, tc0;

  logic        cur_req_ready, cur_resp_valid, cur_err;
  logic [31:0] cur_rdata;
  logic [15:0] cur_txn;

  logic [31:0] model [2][DEPTH];
  logic [15:0] txn_exp [2];
  exp_t        sb [$];
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(2), .CNT_W(16)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid & ~sel),
    .req_ready  (rr2),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_be     (req_be),
    .resp_valid (rv2),
    .resp_ready (resp_ready & ~sel),
    .resp_rdata (rd2),
    .resp_err   (er2),
    .txn_count  (tc2)
  );

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0), .CNT_W(16)) u_dut0 (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid & sel),
    .req_ready  (rr0),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_be     (req_be),
    .resp_valid (rv0),
    .resp_ready (resp_ready & sel),
    .resp_rdata (rd0),
    .resp_err   (er0),
    .txn_count  (tc0)
  );

  assign cur_req_ready  = sel ? rr0 : rr2;
  assign cur_resp_valid = sel ? rv0 : rv2;
  assign cur_rdata      = sel ? rd0 : rd2;
  assign cur_err        = sel ? er0 : er2;
  assign cur_txn        = sel ? tc0 : tc2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drives one request, predicts the response, then collects and retires it.
  task automatic txn(input logic s, input logic w, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] be, input int hold);
    exp_t        e;
    exp_t        got;
    int          n;
    logic [31:0] mask;
    logic [31:0] held;
    logic [31:0] wi;
    sel       = s;
    req_write = w;
    req_addr  = a;
    req_wdata = wd;
    req_be    = be;
    req_valid = 1'b1;
    n = 0;
    while (!cur_req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("req_ready_idle", 32'(cur_req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    e.err = (a[1:0] != 2'b00) || (a[31:2] >= 30'(DEPTH));
    wi    = a >> 2;
    e.rdata = e.err ? 32'h0 : model[s][wi[6:0]];
    if (w && !e.err) begin
      mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
      model[s][wi[6:0]] = (e.rdata & ~mask) | (wd & mask);
    end
    sb.push_back(e);
    n = 0;
    while (!cur_resp_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("latency", 32'(n), s ? 32'd1 : 32'd3);
    got = sb.pop_front();
    check("rdata", cur_rdata, got.rdata);
    check("err", 32'(cur_err), 32'(got.err));
    held = cur_rdata;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(cur_resp_valid), 32'd1);
      check("hold_rdata", cur_rdata, held);
      check("hold_req_ready", 32'(cur_req_ready), 32'd0);
      check("hold_txn", 32'(cur_txn), 32'(txn_exp[s]));
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    txn_exp[s] = txn_exp[s] + 16'd1;
    check("txn_count", 32'(cur_txn), 32'(txn_exp[s]));
    check("post_resp_valid", 32'(cur_resp_valid), 32'd0);
    check("post_req_ready", 32'(cur_req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      model[0][i] = 32'(i);
      model[1][i] = 32'(i);
    end
    txn_exp[0] = '0;
    txn_exp[1] = '0;

    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_req_ready", 32'(rr2), 32'd1);
    check("rst_resp_valid", 32'(rv2), 32'd0);
    check("rst_rdata", rd2, 32'h0);
    check("rst_err", 32'(er2), 32'd0);
    check("rst_txn", 32'(tc2), 32'd0);

    txn(1'b0, 1'b0, 32'h20, 32'h0, 4'h0, 0);
    txn(1'b0, 1'b1, 32'h10, 32'hAABBCCDD, 4'b0101, 0);
    txn(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, 0);
    txn(1'b0, 1'b0, 32'h22, 32'h0, 4'h0, 0);
    txn(1'b0, 1'b0, 32'h200, 32'h0, 4'h0, 0);
    txn(1'b0, 1'b1, 32'h11, 32'h12345678, 4'hF, 0);
    txn(1'b0, 1'b1, 32'h204, 32'h12345678, 4'hF, 0);
    txn(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, 0);
    txn(1'b0, 1'b1, 32'h30, 32'hFFFFFFFF, 4'h0, 0);
    txn(1'b0, 1'b0, 32'h30, 32'h0, 4'h0, 0);
    txn(1'b0, 1'b0, 32'h1FC, 32'h0, 4'h0, 5);
    txn(1'b0, 1'b1, 32'h1FC, 32'hCAFEF00D, 4'b1010, 0);
    txn(1'b0, 1'b0, 32'h1FC, 32'h0, 4'h0, 0);
    for (int i = 0; i < 6; i++) begin
      txn(1'b0, 1'($urandom_range(0, 1)), {23'h0, 7'($urandom_range(0, 127)), 2'b00},
          $urandom, 4'($urandom_range(0, 15)), 0);
    end

    // Reset while a store to word 0 is waiting: the store must vanish.
    sel       = 1'b0;
    req_write = 1'b1;
    req_addr  = 32'h0;
    req_wdata = 32'hDEADBEEF;
    req_be    = 4'hF;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    txn_exp[0] = '0;
    txn_exp[1] = '0;
    check("rst_busy_req_ready", 32'(rr2), 32'd1);
    check("rst_busy_resp_valid", 32'(rv2), 32'd0);
    check("rst_busy_txn", 32'(tc2), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    check("rst_busy_no_resp", 32'(rv2), 32'd0);
    txn(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 0);

    txn(1'b1, 1'b0, 32'h4, 32'h0, 4'h0, 0);
    txn(1'b1, 1'b0, 32'h8, 32'h0, 4'h0, 0);
    txn(1'b1, 1'b0, 32'h1FC, 32'h0, 4'h0, 0);
    check("w0_txn_total", 32'(tc0), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
